// File: rtl/vend_dispense_ctrl.sv
// Vending dispense controller: after a selection, waits for enough credit and then
// releases the item and returns change, or refunds the credit on cancel or timeout.
module vend_dispense_ctrl #(
    parameter int CURRENCY_WIDTH = 7,
    parameter int PRICE0         = 15,
    parameter int PRICE1         = 20,
    parameter int PRICE2         = 25,
    parameter int PRICE3         = 30,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [CURRENCY_WIDTH-1:0] total_currency,
    input  logic                      currency_avail,
    input  logic [1:0]                item_select,
    input  logic                      item_select_valid,
    input  logic                      cancel,
    output logic [1:0]                item_dispense,
    output logic                      item_dispense_valid,
    output logic [CURRENCY_WIDTH-1:0] change_value,
    output logic                      change_valid,
    output logic                      clear_currency,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FUNDS,
        DISPENSE,
        CHANGE,
        REFUND
    } state_t;

    function automatic logic [CURRENCY_WIDTH-1:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    price_of = CURRENCY_WIDTH'(PRICE0);
            2'd1:    price_of = CURRENCY_WIDTH'(PRICE1);
            2'd2:    price_of = CURRENCY_WIDTH'(PRICE2);
            default: price_of = CURRENCY_WIDTH'(PRICE3);
        endcase
    endfunction

    // Wraps in CURRENCY_WIDTH bits; credit is only latched once it covers the price.
    function automatic logic [CURRENCY_WIDTH-1:0] change_of(
        input logic [CURRENCY_WIDTH-1:0] credit,
        input logic [CURRENCY_WIDTH-1:0] price
    );
        change_of = credit - price;
    endfunction

    state_t                    state_q, state_d;
    logic [1:0]                item_q, item_d;
    logic [CURRENCY_WIDTH-1:0] price_q, price_d;
    logic [CURRENCY_WIDTH-1:0] credit_q, credit_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CURRENCY_WIDTH-1:0] prev_total_q;

    logic [1:0]                item_dispense_d;
    logic                      item_dispense_valid_d;
    logic [CURRENCY_WIDTH-1:0] change_value_d;
    logic                      change_valid_d;
    logic                      clear_currency_d;
    logic                      busy_d;
    logic                      timeout_err_d;

    logic                      total_changed;
    logic                      funds_ok;
    logic [CURRENCY_WIDTH-1:0] refund_value;
    logic [CURRENCY_WIDTH-1:0] diff;

    assign total_changed = (total_currency != prev_total_q);
    assign funds_ok      = currency_avail && (total_currency >= price_q);
    assign refund_value  = currency_avail ? total_currency : '0;
    assign diff          = change_of(credit_q, price_q);

    always_comb begin
        state_d               = state_q;
        item_d                = item_q;
        price_d               = price_q;
        credit_d              = credit_q;
        cnt_d                 = cnt_q;
        item_dispense_d       = '0;
        item_dispense_valid_d = 1'b0;
        change_value_d        = '0;
        change_valid_d        = 1'b0;
        clear_currency_d      = 1'b0;
        timeout_err_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (item_select_valid) begin
                    item_d  = item_select;
                    price_d = price_of(item_select);
                    cnt_d   = '0;
                    state_d = WAIT_FUNDS;
                end
            end
            WAIT_FUNDS: begin
                if (cancel) begin
                    state_d          = REFUND;
                    clear_currency_d = 1'b1;
                    change_valid_d   = currency_avail;
                    change_value_d   = refund_value;
                end else if (funds_ok) begin
                    state_d               = DISPENSE;
                    credit_d              = total_currency;
                    item_dispense_valid_d = 1'b1;
                    item_dispense_d       = item_q;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    if (currency_avail) begin
                        state_d          = REFUND;
                        clear_currency_d = 1'b1;
                        change_valid_d   = 1'b1;
                        change_value_d   = refund_value;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = total_changed ? '0 : cnt_q + CNT_W'(1);
                end
            end
            DISPENSE: begin
                // Outputs are registered, so the CHANGE-cycle pulses are prepared here.
                state_d          = CHANGE;
                clear_currency_d = 1'b1;
                change_valid_d   = (diff != '0);
                change_value_d   = diff;
            end
            CHANGE:  state_d = IDLE;
            REFUND:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q             <= IDLE;
            item_q              <= '0;
            price_q             <= '0;
            credit_q            <= '0;
            cnt_q               <= '0;
            prev_total_q        <= '0;
            item_dispense       <= '0;
            item_dispense_valid <= 1'b0;
            change_value        <= '0;
            change_valid        <= 1'b0;
            clear_currency      <= 1'b0;
            busy                <= 1'b0;
            timeout_err         <= 1'b0;
        end else begin
            state_q             <= state_d;
            item_q              <= item_d;
            price_q             <= price_d;
            credit_q            <= credit_d;
            cnt_q               <= cnt_d;
            prev_total_q        <= total_currency;
            item_dispense       <= item_dispense_d;
            item_dispense_valid <= item_dispense_valid_d;
            change_value        <= change_value_d;
            change_valid        <= change_valid_d;
            clear_currency      <= clear_currency_d;
            busy                <= busy_d;
            timeout_err         <= timeout_err_d;
        end
    end

endmodule
